// File: rtl/alu_issue_if.sv
// ============================================================================
// alu_issue_if : operand-issue bus between register-read, alu_issue and ALU
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface alu_issue_if #(
  parameter int WORD_SIZE = 32
);
  // Upstream (decode / register read) side
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          instr;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] rs1_data;
  logic [WORD_SIZE-1:0] rs2_data;

  // Downstream (ALU) side
  logic                 out_valid;
  logic                 out_ready;
  logic [2:0]           alu_op;
  logic [WORD_SIZE-1:0] arg1;
  logic [WORD_SIZE-1:0] arg2;
  logic                 shr_arith;
  logic [1:0]           cmp_sel;
  logic [4:0]           rd;
  logic                 wb_en;
  logic                 illegal_instr;

  // Environment view: feeds instructions, consumes issued operations
  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_op, arg1, arg2, shr_arith, cmp_sel,
           rd, wb_en, illegal_instr
  );

  // Issue-block view
  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_op, arg1, arg2, shr_arith, cmp_sel,
           rd, wb_en, illegal_instr
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue.sv
// ============================================================================
// alu_issue : RV32I integer-compute decoder issuing through a 2-entry skid
// Revision  : 1.0
// ============================================================================
`default_nettype none

module alu_issue #(
  parameter int WORD_SIZE = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SL   = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SHL = 3'd3;
  localparam logic [2:0] ALU_SHR = 3'd4;
  localparam logic [2:0] ALU_ADD = 3'd5;
  localparam logic [2:0] ALU_SUB = 3'd6;

  localparam logic [1:0] CMP_NONE = 2'b00;
  localparam logic [1:0] CMP_SLT  = 2'b01;
  localparam logic [1:0] CMP_SLTU = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0]           alu_op;
    logic [WORD_SIZE-1:0] arg1;
    logic [WORD_SIZE-1:0] arg2;
    logic                 shr_arith;
    logic [1:0]           cmp_sel;
    logic [4:0]           rd;
    logic                 wb_en;
  } entry_t;

  function automatic logic [2:0] f3_alu(input logic [2:0] f3);
    case (f3)
      F3_ADD:  f3_alu = ALU_ADD;
      F3_SL:   f3_alu = ALU_SHL;
      F3_SLT:  f3_alu = ALU_SUB;
      F3_SLTU: f3_alu = ALU_SUB;
      F3_XOR:  f3_alu = ALU_XOR;
      F3_SR:   f3_alu = ALU_SHR;
      F3_OR:   f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction

  function automatic logic [1:0] f3_cmp(input logic [2:0] f3);
    case (f3)
      F3_SLT:  f3_cmp = CMP_SLT;
      F3_SLTU: f3_cmp = CMP_SLTU;
      default: f3_cmp = CMP_NONE;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [6:0]           opcode_w;
  logic [2:0]           funct3_w;
  logic [6:0]           funct7_w;
  logic [4:0]           rd_w;
  logic [WORD_SIZE-1:0] imm_i_w;
  logic [WORD_SIZE-1:0] imm_u_w;
  logic [WORD_SIZE-1:0] shamt_w;
  entry_t               dec_w;
  logic                 legal_w;

  assign opcode_w = bus.instr[6:0];
  assign funct3_w = bus.instr[14:12];
  assign funct7_w = bus.instr[31:25];
  assign rd_w     = bus.instr[11:7];
  assign imm_i_w  = WORD_SIZE'($signed(bus.instr[31:20]));
  assign imm_u_w  = WORD_SIZE'($signed({bus.instr[31:12], 12'b0}));
  assign shamt_w  = WORD_SIZE'(bus.instr[24:20]);

  always_comb begin
    dec_w         = '0;
    legal_w       = 1'b0;
    dec_w.rd      = rd_w;
    dec_w.wb_en   = (rd_w != 5'd0);
    dec_w.alu_op  = f3_alu(funct3_w);
    dec_w.cmp_sel = f3_cmp(funct3_w);
    dec_w.arg1    = bus.rs1_data;
    case (opcode_w)
      OPC_OP: begin
        dec_w.arg2 = bus.rs2_data;
        if (funct7_w == F7_BASE) begin
          legal_w = 1'b1;
        end else if (funct7_w == F7_ALT) begin
          legal_w = (funct3_w == F3_ADD) || (funct3_w == F3_SR);
        end
        if ((funct3_w == F3_ADD) && funct7_w[5]) begin
          dec_w.alu_op = ALU_SUB;
        end
        dec_w.shr_arith = (funct3_w == F3_SR) && funct7_w[5];
      end
      OPC_OP_IMM: begin
        // Immediate form has no subtract; funct7 only qualifies shifts
        dec_w.arg2 = imm_i_w;
        case (funct3_w)
          F3_SL: begin
            legal_w    = (funct7_w == F7_BASE);
            dec_w.arg2 = shamt_w;
          end
          F3_SR: begin
            legal_w         = (funct7_w == F7_BASE) || (funct7_w == F7_ALT);
            dec_w.arg2      = shamt_w;
            dec_w.shr_arith = funct7_w[5];
          end
          default: legal_w = 1'b1;
        endcase
      end
      OPC_LUI: begin
        legal_w       = 1'b1;
        dec_w.alu_op  = ALU_ADD;
        dec_w.cmp_sel = CMP_NONE;
        dec_w.arg1    = '0;
        dec_w.arg2    = imm_u_w;
      end
      OPC_AUIPC: begin
        legal_w       = 1'b1;
        dec_w.alu_op  = ALU_ADD;
        dec_w.cmp_sel = CMP_NONE;
        dec_w.arg1    = bus.pc;
        dec_w.arg2    = imm_u_w;
      end
      default: legal_w = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Skid buffer: main_q drives the outputs, skid_q absorbs one overflow entry
  // --------------------------------------------------------------------------
  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q;
  logic   illegal_q;
  logic   accept_w;
  logic   load_w;
  logic   pop_w;
  logic   out_valid_w;

  assign out_valid_w = (state_q != EMPTY);
  assign accept_w    = bus.in_valid && in_ready_q;
  assign load_w      = accept_w && legal_w;
  assign pop_w       = out_valid_w && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (load_w) begin
          state_d = ONE;
          main_d  = dec_w;
        end
      end
      ONE: begin
        if (load_w && !pop_w) begin
          state_d = FULL;
          skid_d  = dec_w;
        end else if (load_w && pop_w) begin
          main_d = dec_w;
        end else if (pop_w) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop_w) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
      illegal_q  <= accept_w && !legal_w;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_w;
  assign bus.alu_op        = main_q.alu_op;
  assign bus.arg1          = main_q.arg1;
  assign bus.arg2          = main_q.arg2;
  assign bus.shr_arith     = main_q.shr_arith;
  assign bus.cmp_sel       = main_q.cmp_sel;
  assign bus.rd            = main_q.rd;
  assign bus.wb_en         = main_q.wb_en;
  assign bus.illegal_instr = illegal_q;

endmodule

`default_nettype wire
